// File: rtl/fetch_if.sv
// Instruction-fetch bus bundle: controller commands, memory handshake and
// the fetch unit's architectural outputs.
interface fetch_if;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        fetch_busy;
  logic        fetch_err;

  // Environment side: controller plus instruction memory.
  modport master (
    output ir_write, pc_write, pc_src, alu_result, alu_out, mem_ack, mem_rdata,
    input  mem_req, mem_addr, pc, instr, opcode, fetch_busy, fetch_err
  );

  // Fetch unit side.
  modport slave (
    input  ir_write, pc_write, pc_src, alu_result, alu_out, mem_ack, mem_rdata,
    output mem_req, mem_addr, pc, instr, opcode, fetch_busy, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register, issues one
// word-aligned read per ir_write and gives up after TIMEOUT wait cycles.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Last WAIT cycle before giving up; the counter lands on TIMEOUT as the
  // fetch is abandoned.
  localparam logic [3:0] WLAST = 4'(TIMEOUT - 1);
  localparam logic [3:0] WFULL = 4'(TIMEOUT);

  state_t      state, state_nx;
  logic [3:0]  wcnt, wcnt_nx;
  logic        err_q, err_nx;
  logic        ld_addr, ld_instr;
  logic [31:0] pc_q, instr_q, addr_q;

  // Control state, wait counter and the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      err_q <= err_nx;
    end
  end

  // Next-state decode; ir_write only matters in IDLE, mem_ack only in REQ/WAIT.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    err_nx   = 1'b0;
    ld_addr  = 1'b0;
    ld_instr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ir_write) begin
          if (pc_q[1:0] == 2'b00) begin
            state_nx = REQ;
            ld_addr  = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          ld_instr = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
          wcnt_nx  = '0;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          ld_instr = 1'b1;
          state_nx = DONE;
        end else if (wcnt == WLAST) begin
          wcnt_nx  = WFULL;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt + 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers. mem_addr captures the pre-update PC so a fetch
  // started alongside a PC write reads from the old address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      if (ld_addr)      addr_q  <= pc_q;
      if (ld_instr)     instr_q <= bus.mem_rdata;
      if (bus.pc_write) pc_q    <= bus.pc_src ? bus.alu_out : bus.alu_result;
    end
  end

  assign bus.mem_req    = (state == REQ) || (state == WAIT);
  assign bus.fetch_busy = (state != IDLE);
  assign bus.fetch_err  = err_q;
  assign bus.mem_addr   = addr_q;
  assign bus.pc         = pc_q;
  assign bus.instr      = instr_q;
  assign bus.opcode     = instr_q[31:26];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-002 SHALL have port ir_write in 1, controller request to fetch the next instruction.
REQ-003 SHALL have ports pc_write in 1 and pc_src in 1, the controller PC update enable and source select.
REQ-004 SHALL have ports alu_result in 32 (sequential PC+4) and alu_out in 32 (registered branch/jump target).
REQ-005 SHALL have ports mem_req out 1, mem_addr out 32, mem_ack in 1 and mem_rdata in 32, the instruction memory handshake.
REQ-006 SHALL have ports pc out 32, instr out 32 (instruction register), opcode out 6 (instr[31:26]), fetch_busy out 1 and fetch_err out 1.
REQ-007 SHALL have parameter RESET_PC, default 32'h0040_0000, the PC value after reset.
REQ-008 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles for mem_ack.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-010 SHALL transition IDLE->REQ on ir_write=1 with pc[1:0]=00, latching mem_addr<=pc at that edge.
REQ-011 SHALL, on ir_write=1 with pc[1:0]!=00, stay in IDLE, issue no request and pulse fetch_err for 1 cycle.
REQ-012 SHALL assert mem_req in REQ and WAIT and hold mem_addr stable until mem_ack is sampled high.
REQ-013 SHALL, in REQ or WAIT with mem_ack=1, latch instr<=mem_rdata and go to DONE; minimum latency is 2 cycles from ir_write to instr update.
REQ-014 SHALL, in REQ with mem_ack=0, go to WAIT with the wait counter cleared to 0.
REQ-015 SHALL increment the 4-bit wait counter once per WAIT cycle.
REQ-016 SHALL, when the wait counter reaches TIMEOUT without mem_ack, drop mem_req, pulse fetch_err for 1 cycle, keep instr unchanged and return to IDLE.
REQ-017 SHALL, in DONE, return to IDLE unconditionally after 1 cycle.
REQ-018 SHALL drive fetch_busy=1 in REQ, WAIT and DONE, and 0 in IDLE.
REQ-019 SHALL update the PC on any edge with pc_write=1, in any state: pc<=alu_out if pc_src=1, else alu_result.
REQ-020 SHALL, when ir_write and pc_write are asserted in the same cycle, fetch from the old pc (mem_addr) while pc takes the new value.
REQ-021 SHALL ignore ir_write in any state other than IDLE: no restart, no error, no queueing.
REQ-022 SHALL ignore mem_ack in IDLE and DONE, so a spurious ack leaves instr unchanged.
REQ-023 SHALL derive opcode combinationally from the registered instr.
REQ-024 SHALL leave mem_addr holding the last fetch address when mem_req=0.

Reset
REQ-025 SHALL, on rst_n=0, immediately set state=IDLE, pc=RESET_PC, instr=0, mem_addr=0, mem_req=0, fetch_busy=0, fetch_err=0 and the wait counter to 0.
REQ-026 SHALL abort an in-flight fetch on reset mid-operation, leaving instr=0; an ack arriving after reset release is ignored (REQ-022).

Verification
REQ-027 SHALL pass this scenario: reset, then ir_write=pc_write=1 with alu_result=0x00400004 and ack in the REQ cycle with rdata=0x20080005 -> mem_addr=0x00400000, pc=0x00400004, instr=0x20080005, opcode=0x08.
REQ-028 SHALL pass this scenario: ack delayed 3 cycles -> mem_req high for 4 cycles, fetch_busy high for 5 cycles, instr updated only on the ack edge.
REQ-029 SHALL pass this scenario: no ack -> fetch_err pulses exactly once, 16 cycles after REQ entry, instr unchanged, state IDLE.
REQ-030 SHALL pass this scenario: pc_write=1, pc_src=1, alu_out=0x00400022, then ir_write -> no mem_req and a 1-cycle fetch_err.
REQ-031 SHALL pass this scenario: rst_n low during WAIT, then ack after release -> instr=0, pc=0x00400000, mem_req=0.
REQ-032 SHALL pass this scenario: ir_write re-asserted during WAIT -> a single fetch completes with no extra request.
